// File: rtl/ootx_uart_frame_scheduler_if.sv
// Source/UART bundle for the frame scheduler: per-source request, length and read port, plus the UART byte handshake.
// The master side is the scheduler; the slave side is the register file and UART.
interface ootx_uart_frame_scheduler_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]   req;
  logic [8*NUM_SRC-1:0] len;
  logic [NUM_SRC-1:0]   grant;
  logic [7:0]           rd_addr;
  logic [7:0]           rd_data;
  logic [NUM_SRC-1:0]   done;
  logic                 tx_dv;
  logic [7:0]           tx_byte;
  logic                 tx_done;
  logic                 busy;

  modport master (
    input  req, len, rd_data, tx_done,
    output grant, rd_addr, done, tx_dv, tx_byte, busy
  );

  modport slave (
    output req, len, rd_data, tx_done,
    input  grant, rd_addr, done, tx_dv, tx_byte, busy
  );
endinterface

// File: rtl/ootx_uart_frame_scheduler.sv
// Round-robin shares one UART between sources, framing each as A5, ID, LEN, payload, CSUM (sum of all but A5).
// One byte per tx_done: header/CSUM bytes leave 1 cycle after tx_done, payload 2 (one-cycle fetch); a slow UART stalls the frame.
module ootx_uart_frame_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int MAX_LEN = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  ootx_uart_frame_scheduler_if.master    bus
);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, WAIT, CSUM, FINISH} state_t;
  typedef enum logic [2:0] {K_SYNC, K_ID, K_LEN, K_PAY, K_CSUM} kind_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] LEN_CAP   = 8'(MAX_LEN);

  state_t     state;
  kind_t      kind;
  logic [1:0] last;
  logic [1:0] id;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       pick_vld;
  logic [7:0] len_q;
  logic [7:0] idx;
  logic [7:0] csum;
  logic [7:0] len_sel;
  logic [7:0] len_clip;
  logic [7:0] hdr_byte;

  // Search starts just after the last granted source so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = 2'((int'(last) + k) % NUM_SRC);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  assign len_sel  = bus.len[{pick, 3'b000} +: 8];
  assign len_clip = (len_sel > LEN_CAP) ? LEN_CAP : len_sel;

  always_comb begin
    hdr_byte = SYNC_BYTE;
    case (kind)
      K_ID:    hdr_byte = {6'd0, id};
      K_LEN:   hdr_byte = len_q;
      default: hdr_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      kind        <= K_SYNC;
      last        <= 2'(NUM_SRC - 1);
      id          <= '0;
      len_q       <= '0;
      idx         <= '0;
      csum        <= '0;
      bus.grant   <= '0;
      bus.done    <= '0;
      bus.tx_dv   <= 1'b0;
      bus.tx_byte <= '0;
      bus.rd_addr <= '0;
      bus.busy    <= 1'b0;
    end else begin
      bus.tx_dv <= 1'b0;
      bus.done  <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            id          <= pick;
            last        <= pick;
            len_q       <= len_clip;
            idx         <= '0;
            csum        <= '0;
            bus.rd_addr <= '0;
            bus.grant   <= NUM_SRC'(1) << pick;
            bus.busy    <= 1'b1;
            kind        <= K_SYNC;
            state       <= HDR;
          end
        end
        HDR: begin
          bus.tx_byte <= hdr_byte;
          bus.tx_dv   <= 1'b1;
          if (kind != K_SYNC) csum <= csum + hdr_byte;
          state <= WAIT;
        end
        FETCH: state <= SEND;
        SEND: begin
          bus.tx_byte <= bus.rd_data;
          bus.tx_dv   <= 1'b1;
          csum        <= csum + bus.rd_data;
          kind        <= K_PAY;
          state       <= WAIT;
        end
        CSUM: begin
          bus.tx_byte <= csum;
          bus.tx_dv   <= 1'b1;
          kind        <= K_CSUM;
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done) begin
            case (kind)
              K_SYNC: begin kind <= K_ID;  state <= HDR; end
              K_ID:   begin kind <= K_LEN; state <= HDR; end
              K_LEN:  state <= (len_q != 8'd0) ? FETCH : CSUM;
              K_PAY: begin
                if (idx == len_q - 8'd1) begin
                  state <= CSUM;
                end else begin
                  idx         <= idx + 8'd1;
                  bus.rd_addr <= idx + 8'd1;
                  state       <= FETCH;
                end
              end
              default: begin
                bus.done  <= NUM_SRC'(1) << id;
                bus.grant <= '0;
                state     <= FINISH;
              end
            endcase
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ootx_uart_frame_scheduler.sv
// Directed bench for the UART frame scheduler: a frame-level model predicts grant order and byte stream, plus literal frame checks.
module tb_ootx_uart_frame_scheduler;
  localparam int NS = 4;
  localparam int ML = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ootx_uart_frame_scheduler_if #(.NUM_SRC(NS)) bus ();

  ootx_uart_frame_scheduler #(.NUM_SRC(NS), .MAX_LEN(ML)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic nat_done  = 1'b0;
  logic spur_done = 1'b0;
  assign bus.tx_done = nat_done | spur_done;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NS-1:0] g);
    for (int i = 0; i < NS; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic int rr_pick(input logic [NS-1:0] r, input int lst);
    for (int k = 1; k <= NS; k++) if (r[(lst + k) % NS]) return (lst + k) % NS;
    return -1;
  endfunction

  // Source payload storage; read data appears one cycle after the address.
  logic [7:0] mem [NS][256];

  initial begin : rd_port
    int sel_d;
    logic [7:0] addr_d;
    sel_d = 0;
    addr_d = '0;
    bus.rd_data = '0;
    forever begin
      @(posedge clock); #1;
      bus.rd_data = mem[sel_d][addr_d];
      addr_d = bus.rd_addr;
      sel_d  = onehot_idx(bus.grant);
    end
  end

  // UART: accepts a byte on tx_dv, answers tx_done after a latency.
  int         accept_id    = 0;
  logic       inflight     = 1'b0;
  logic [7:0] held         = '0;
  bit         accepted_now = 1'b0;
  bit         soak         = 1'b0;
  int         lat_fixed    = 10;

  initial begin : uart
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock); #1;
      nat_done = 1'b0;
      accepted_now = 1'b0;
      if (inflight) begin
        cnt--;
        if (cnt <= 0) begin
          nat_done = 1'b1;
          inflight = 1'b0;
        end
      end else if (bus.tx_dv) begin
        inflight = 1'b1;
        held = bus.tx_byte;
        accepted_now = 1'b1;
        accept_id++;
        cnt = soak ? int'($urandom_range(50, 1)) : lat_fixed;
      end
    end
  end

  logic [NS-1:0]   req_s;
  logic [8*NS-1:0] len_s;
  logic            rst_s = 1'b1;
  always @(posedge clock) begin
    req_s <= bus.req;
    len_s <= bus.len;
    rst_s <= reset;
  end

  logic [7:0]    exp_q[$];
  logic [7:0]    log_bytes[$];
  logic [7:0]    rd_log[$];
  int            log_grants[$];
  int            m_last        = NS - 1;
  int            cur_id        = 0;
  int            cur_len       = 0;
  int            frame_bytes   = 0;
  int            since_done    = 100;
  int            since_grant   = 0;
  int            dv_total      = 0;
  int            done_total    = 0;
  int            rst_accept_id = -1;
  int            done_cnt [NS];
  logic [NS-1:0] prev_grant    = '0;

  always @(negedge clock) begin : compare
    int id;
    int ln;
    int sum;
    int gap;
    logic [7:0] e;
    if (rst_s) begin
      check(bus.grant == 0 && bus.done == 0 && !bus.tx_dv && !bus.busy && bus.rd_addr == 0 && bus.tx_byte == 0,
            "reset_outputs", {bus.busy, bus.tx_dv, bus.done, bus.grant, bus.rd_addr, bus.tx_byte}, 0);
      exp_q.delete();
      m_last = NS - 1;
      prev_grant = '0;
      rst_accept_id = accept_id;
    end else begin
      since_done = nat_done ? 0 : since_done + 1;
      since_grant++;
      if (prev_grant == 0 && bus.grant != 0) begin
        id = rr_pick(req_s, m_last);
        check(id >= 0 && bus.grant == (NS'(1) << id), "grant_pick", bus.grant, (id >= 0) ? (1 << id) : 0);
        if (id < 0) id = onehot_idx(bus.grant);
        m_last = id;
        cur_id = id;
        ln = int'(len_s[8*id +: 8]);
        if (ln > ML) ln = ML;
        cur_len = ln;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(id));
        exp_q.push_back(8'(ln));
        sum = id + ln;
        for (int k = 0; k < ln; k++) begin
          exp_q.push_back(mem[id][k]);
          sum += int'(mem[id][k]);
        end
        exp_q.push_back(8'(sum % 256));
        log_grants.push_back(id);
        rd_log.delete();
        rd_log.push_back(bus.rd_addr);
        frame_bytes = 0;
        since_grant = 0;
      end else if (bus.grant != 0) begin
        check(bus.grant == prev_grant, "grant_held", bus.grant, prev_grant);
        if (bus.rd_addr != rd_log[$]) rd_log.push_back(bus.rd_addr);
      end
      check(bus.busy == (bus.grant != 0 || bus.done != 0), "busy", bus.busy, (bus.grant != 0 || bus.done != 0));
      if (bus.tx_dv) begin
        dv_total++;
        if (exp_q.size() == 0) begin
          check(1'b0, "tx_unexpected", bus.tx_byte, 0);
        end else begin
          e = exp_q.pop_front();
          check(bus.tx_byte == e, "tx_byte", bus.tx_byte, e);
        end
        if (frame_bytes == 0) begin
          check(since_grant == 1, "first_dv_gap", since_grant, 1);
        end else begin
          gap = (frame_bytes >= 3 && frame_bytes < 3 + cur_len) ? 3 : 2;
          check(since_done == gap, "tx_gap", since_done, gap);
        end
        check(accepted_now && !bus.tx_done, "tx_dv_handshake", {accepted_now, bus.tx_done}, 2);
        log_bytes.push_back(bus.tx_byte);
        frame_bytes++;
      end
      if (inflight && !accepted_now && accept_id != rst_accept_id)
        check(bus.tx_byte == held, "tx_byte_stable", bus.tx_byte, held);
      if (bus.done != 0) begin
        check(bus.done == (NS'(1) << cur_id) && bus.grant == 0 && exp_q.size() == 0, "done_frame",
              {bus.grant, bus.done}, (1 << cur_id));
        done_cnt[cur_id]++;
        done_total++;
      end
      prev_grant = bus.grant;
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic set_len(input int s, input int v);
    bus.len[8*s +: 8] = 8'(v);
  endtask

  task automatic run_frame(input int src, input int max_cycles);
    int g0;
    int d0;
    g0 = log_grants.size();
    d0 = done_total;
    log_bytes.delete();
    bus.req[src] = 1'b1;
    for (int n = 0; n < max_cycles && log_grants.size() == g0; n++) begin
      @(posedge clock); #1;
    end
    bus.req[src] = 1'b0;
    for (int n = 0; n < max_cycles && done_total == d0; n++) begin
      @(posedge clock); #1;
    end
    check(done_total == d0 + 1, "frame_complete", done_total - d0, 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_bytes(input string name, input logic [7:0] want[$]);
    check(log_bytes.size() == want.size(), {name, "_len"}, log_bytes.size(), want.size());
    for (int i = 0; i < want.size() && i < log_bytes.size(); i++)
      check(log_bytes[i] == want[i], name, log_bytes[i], want[i]);
  endtask

  task automatic spur_fetch();
    for (int n = 0; n < 500; n++) begin
      @(posedge clock); #2;
      if (nat_done && frame_bytes == 3 && bus.grant[2]) break;
    end
    @(posedge clock); #1;
    spur_done = 1'b1;
    @(posedge clock); #1;
    spur_done = 1'b0;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g0;
    int d0;
    int dv0;
    int d1;
    bus.req = '0;
    bus.len = '0;
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < 256; a++) mem[s][a] = 8'(s * 64 + a + 7);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single source frame
    mem[1][0] = 8'h11;
    mem[1][1] = 8'h22;
    set_len(1, 2);
    run_frame(1, 2000);
    check_bytes("single_frame", '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h36});
    check(rd_log.size() == 2 && rd_log[0] == 8'd0 && rd_log[1] == 8'd1, "rd_addr_seq",
          {rd_log.size(), rd_log[0], rd_log[$]}, 32'h0002_0001);
    check(done_cnt[1] == 1, "single_done_once", done_cnt[1], 1);

    // Round robin with all four requesting
    do_reset();
    set_len(0, 1); set_len(1, 0); set_len(2, 2); set_len(3, 1);
    g0 = log_grants.size();
    d0 = done_total;
    bus.req = 4'b1111;
    for (int n = 0; n < 5000 && log_grants.size() < g0 + 5; n++) begin @(posedge clock); #1; end
    bus.req = '0;
    for (int n = 0; n < 2000 && done_total < d0 + 5; n++) begin @(posedge clock); #1; end
    check(log_grants.size() == g0 + 5, "rr_count", log_grants.size() - g0, 5);
    if (log_grants.size() >= g0 + 5)
      check(log_grants[g0] == 0 && log_grants[g0+1] == 1 && log_grants[g0+2] == 2 && log_grants[g0+3] == 3 &&
            log_grants[g0+4] == 0, "rr_order",
            {log_grants[g0][3:0], log_grants[g0+1][3:0], log_grants[g0+2][3:0], log_grants[g0+3][3:0],
             log_grants[g0+4][3:0]}, 32'h01230);

    // Requests shrink to source 2 after the first grant
    do_reset();
    g0 = log_grants.size();
    d0 = done_total;
    bus.req = 4'b1111;
    for (int n = 0; n < 2000 && log_grants.size() < g0 + 1; n++) begin @(posedge clock); #1; end
    bus.req = 4'b0100;
    for (int n = 0; n < 5000 && log_grants.size() < g0 + 3; n++) begin @(posedge clock); #1; end
    bus.req = '0;
    for (int n = 0; n < 2000 && done_total < d0 + 3; n++) begin @(posedge clock); #1; end
    check(log_grants.size() == g0 + 3, "rr2_count", log_grants.size() - g0, 3);
    if (log_grants.size() >= g0 + 3)
      check(log_grants[g0] == 0 && log_grants[g0+1] == 2 && log_grants[g0+2] == 2, "rr2_order",
            {log_grants[g0][3:0], log_grants[g0+1][3:0], log_grants[g0+2][3:0]}, 32'h022);

    // Boundaries: empty payload, length clip, checksum wrap
    do_reset();
    set_len(3, 0);
    run_frame(3, 2000);
    check_bytes("len0_frame", '{8'hA5, 8'h03, 8'h00, 8'h03});
    for (int a = 0; a < 256; a++) mem[0][a] = 8'(3 * a + 1);
    set_len(0, 200);
    run_frame(0, 20000);
    check(log_bytes.size() == 68, "clip_size", log_bytes.size(), 68);
    if (log_bytes.size() == 68) begin
      check(log_bytes[2] == 8'h40, "clip_len_byte", log_bytes[2], 8'h40);
      check(log_bytes[67] == 8'h20, "clip_csum", log_bytes[67], 8'h20);
    end
    check(rd_log.size() > 0 && rd_log[$] == 8'd63, "clip_last_addr", rd_log[$], 63);
    mem[0][0] = 8'hFF; mem[0][1] = 8'hFF; mem[0][2] = 8'hFF;
    set_len(0, 3);
    run_frame(0, 2000);
    check_bytes("csum_wrap", '{8'hA5, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00});

    // Spurious tx_done in IDLE and in FETCH
    do_reset();
    repeat (2) @(posedge clock);
    #1;
    dv0 = dv_total;
    spur_done = 1'b1;
    @(posedge clock); #1;
    spur_done = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check(!bus.busy && dv_total == dv0, "spur_idle", {bus.busy, 8'(dv_total - dv0)}, 0);
    mem[2][0] = 8'h05; mem[2][1] = 8'h06; mem[2][2] = 8'h07;
    set_len(2, 3);
    fork
      run_frame(2, 2000);
      spur_fetch();
    join
    check_bytes("spur_fetch_frame", '{8'hA5, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h17});

    // Reset while the sixth payload byte is in flight
    do_reset();
    d1 = done_cnt[1];
    for (int a = 0; a < 8; a++) mem[1][a] = 8'(8'h30 + a);
    set_len(1, 8);
    bus.req[1] = 1'b1;
    for (int n = 0; n < 2000 && !(frame_bytes == 9 && bus.grant[1]); n++) begin @(posedge clock); #1; end
    bus.req[1] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    dv0 = dv_total;
    repeat (40) @(posedge clock);
    #1;
    check(!bus.busy && dv_total == dv0, "late_done_ignored", {bus.busy, 8'(dv_total - dv0)}, 0);
    check(done_cnt[1] == d1, "aborted_no_done", done_cnt[1], d1);
    mem[2][0] = 8'h5A;
    set_len(2, 1);
    run_frame(2, 2000);
    check_bytes("post_reset_frame", '{8'hA5, 8'h02, 8'h01, 8'h5A, 8'h5D});

    // Soak with random UART latency and random payloads
    soak = 1'b1;
    do_reset();
    for (int s = 0; s < NS; s++) begin
      set_len(s, $urandom_range(6, 0));
      for (int a = 0; a < 8; a++) mem[s][a] = 8'($urandom_range(255, 0));
    end
    d0 = done_total;
    bus.req = 4'b1111;
    for (int n = 0; n < 30000 && done_total < d0 + 12; n++) begin @(posedge clock); #1; end
    bus.req = '0;
    for (int n = 0; n < 2000 && bus.busy; n++) begin @(posedge clock); #1; end
    check(done_total - d0 >= 12 && !bus.busy && exp_q.size() == 0, "soak_complete",
          {bus.busy, 8'(done_total - d0)}, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ootx_uart_frame_scheduler.md
# ootx_uart_frame_scheduler

Shares one byte-wide UART transmitter (`i_Tx_DV`/`i_Tx_Byte`/`o_Tx_Done` handshake, e.g. the 434-clock-per-bit instance) between up to four frame sources. Sources include the per-lighthouse OOTX payload registers and sweep/status dumps. A round-robin arbiter grants one pending source at a time. The block fetches that source's bytes through an indexed read port and wraps them in a framed packet: sync, source ID, length, payload, checksum. It sits between the decoder-side registers and the UART, replacing per-source ad-hoc byte sequencers.

## Interface
Parameters:
- `NUM_SRC`, 4: number of sources, legal range 1..4.
- `MAX_LEN`, 64: maximum payload bytes per frame, legal range 1..255.

Ports:
- `clock`  in  1: single clock domain.
- `reset`  in  1: synchronous, active-high.
- `req`  in  NUM_SRC: level; source i has a frame pending.
- `len`  in  8*NUM_SRC: payload byte count of source i in bits [8i+7:8i]; sampled at grant.
- `grant`  out  NUM_SRC: one-hot; held for the whole frame.
- `rd_addr`  out  8: payload byte index requested from the granted source.
- `rd_data`  in  8: byte at `rd_addr`; valid exactly one cycle after `rd_addr` changes.
- `done`  out  NUM_SRC: one-cycle pulse on bit i when the frame of source i has fully left the UART.
- `tx_dv`  out  1: one-cycle start pulse to the UART.
- `tx_byte`  out  8: byte to the UART; stable from the `tx_dv` cycle until `tx_done`.
- `tx_done`  in  1: UART byte-complete pulse.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- Wire frame: 0xA5, ID (8'd0..3), LEN, payload[0..LEN-1], CSUM. CSUM = (ID + LEN + Σpayload) mod 256. 0xA5 is excluded from the sum.
- LEN = min(`len[i]`, MAX_LEN). It is latched at grant, and later changes to `len` are ignored. LEN = 0 is legal; the frame is then A5, ID, 00, CSUM = ID.
- Round-robin: `last` pointer resets to NUM_SRC-1, so source 0 has first priority. The search order is last+1, last+2, … modulo NUM_SRC. `last` updates to the granted index at grant.
- FSM states:
  - IDLE: if any `req` bit is set, latch ID/LEN, assert `grant`, clear the byte index and checksum, go to HDR.
  - HDR: sequence 0xA5 → ID → LEN, each as SEND→WAIT. After LEN, go to FETCH if LEN>0, else to CSUM.
  - FETCH: drive `rd_addr` = index and wait one cycle for `rd_data`, then SEND.
  - SEND: load `tx_byte`, pulse `tx_dv`, accumulate the checksum for bytes other than 0xA5, go to WAIT.
  - WAIT: on `tx_done`, advance. The next payload byte goes to FETCH (index+1). After the last payload byte go to CSUM. After the CSUM byte go to FINISH.
  - CSUM: send the accumulated sum through SEND/WAIT.
  - FINISH: pulse `done[ID]`, drop `grant`, return to IDLE.
- The index counter is 8 bits and never exceeds LEN-1, so it does not wrap.
- The checksum accumulator is 8 bits and wraps modulo 256.
- Dropping `req` mid-frame is ignored; the frame always completes.
- A `req` still high after `done` re-competes in the next IDLE cycle but loses to other pending sources.
- `tx_done` outside WAIT is ignored.

## Timing
- Reset values:
  - Outputs `grant`, `done`, `tx_dv`, `busy` = 0.
  - Output `rd_addr` = 0.
  - Output `tx_byte` = 0.
  - Internal: `last` = NUM_SRC-1, state IDLE.
- Reset mid-frame returns to these values on the next edge. A UART byte already in flight is not aborted. Any subsequent `tx_done` lands in IDLE and is ignored.
- `req` seen in IDLE at edge n → `grant` and `busy` high after edge n. First `tx_dv` (0xA5) follows 1 cycle later.
- `tx_done` at edge m → next `tx_dv` at m+1 for header and CSUM bytes, or m+2 for payload bytes (one-cycle FETCH).
- Last `tx_done` (CSUM) at edge m → `done[ID]` pulse and `grant` low at m+1. Earliest next `grant` is at m+2.
- At most one `tx_dv` is issued per `tx_done`. `tx_dv` never coincides with `tx_done`.

## Test plan
- Single source: source 1 has req, len=2, bytes 11,22 → UART sees A5 01 02 11 22 36. `done[1]` pulses once. `rd_addr` sequence is 0, 1.
- Round-robin: `req`=4'b1111 held for 5 frames → grant order 0,1,2,3,0. Then `req` drops to 4'b0100 after the first frame → order 0,2,2.
- Boundaries: len=0 on source 3 → A5 03 00 03. len=200 with MAX_LEN=64 → LEN byte 0x40 and 64 payload bytes. Payload 0xFF×3 with ID 0, LEN 3 → CSUM 0x00 (wrap).
- Handshake abuse: spurious `tx_done` in IDLE and FETCH → no state change and no extra `tx_dv`. Drop `req` mid-frame → frame completes intact.
- Reset mid-frame: assert `reset` while in WAIT of payload byte 5 → all outputs reach reset values next edge. A late `tx_done` is ignored. Next `req` on source 2 → full new frame starting with A5 02.
- UART latency: the UART model returns `tx_done` 10 cycles after `tx_dv` (random 1..50 in a soak run) → no byte is dropped or duplicated, and `tx_byte` is stable through each byte.
